cdb_arbiter: RTL and testbench

Responder side of the CDB request handshake used by the load/store unit and the other functional units. Each cycle it grants at most one requester per CDB, latches the winner's tag, and drives the common data bus one cycle later with that tag and the requester's result. One instance serves the GPR CDB and a second serves the FPR CDB. The requester sees `valid && ready` as dispatch, so `ready` must be combinational.

---
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// CDB responder: grants one requester per cycle and broadcasts its tag/result on the next cycle.
// Define CDB_ARB_RR_EN for round-robin selection; otherwise the lowest index wins.
module cdb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*ROB_WIDTH-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    input  logic                        failure,
    output logic                        cdb_valid,
    output logic [ROB_WIDTH-1:0]        cdb_tag,
    output logic [DATA_W-1:0]           cdb_data
);

    localparam int IDX_W = $clog2(N_REQ);

    logic                 grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [ROB_WIDTH-1:0] grant_tag;
    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;
    logic [ROB_WIDTH-1:0] win_tag;

`ifdef CDB_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    always_comb begin
        int j;
        grant     = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!grant && req_valid[j]) begin
                grant     = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        if (reset || failure) grant = 1'b0;
    end

    // Pointer moves one past the winner so the winner becomes lowest priority next time.
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant)
            rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
`else
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant     = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        if (reset || failure) grant = 1'b0;
    end
`endif

    always_comb begin
        req_ready = '0;
        grant_tag = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                req_ready[i] = grant;
                grant_tag    = req_tag[i*ROB_WIDTH +: ROB_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_idx   <= '0;
            win_tag   <= '0;
        end else begin
            win_valid <= grant;
            if (grant) begin
                win_idx <= grant_idx;
                win_tag <= grant_tag;
            end
        end
    end

    // Result is taken live from the winner one cycle after its grant.
    always_comb begin
        cdb_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) cdb_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign cdb_valid = win_valid;
    assign cdb_tag   = win_tag;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter; rows are consecutive clock cycles.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            failure;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;

    cdb_arbiter #(.N_REQ(N), .DATA_W(DW), .ROB_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_data(req_data), .failure(failure),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    // Requester i presents tag tb+i and data db+i.
    typedef struct {
        logic          rst;
        logic          fail;
        logic [N-1:0]  valid;
        logic [TW-1:0] tb;
        logic [DW-1:0] db;
        logic [N-1:0]  e_ready;
        logic          e_cv;
        logic [TW-1:0] e_tag;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fail, input logic [N-1:0] valid,
                         input logic [TW-1:0] tb, input logic [DW-1:0] db);
        reset     = rst;
        failure   = fail;
        req_valid = valid;
        for (int i = 0; i < N; i++) begin
            req_tag[i*TW +: TW]  = tb + TW'(i);
            req_data[i*DW +: DW] = db + DW'(i);
        end
    endtask

    task automatic add(input logic rst, input logic fail, input logic [N-1:0] valid,
                       input logic [TW-1:0] tb, input logic [DW-1:0] db, input logic [N-1:0] e_ready,
                       input logic e_cv, input logic [TW-1:0] e_tag, input logic [DW-1:0] e_data);
        vec_t v;
        v.rst = rst; v.fail = fail; v.valid = valid; v.tb = tb; v.db = db;
        v.e_ready = e_ready; v.e_cv = e_cv; v.e_tag = e_tag; v.e_data = e_data;
        vecs.push_back(v);
    endtask

    task automatic step_check(input int row, input vec_t v);
        @(posedge clk);
        #1;
        drive(v.rst, v.fail, v.valid, v.tb, v.db);
        #3;
        chk("req_ready", row, 32'(req_ready), 32'(v.e_ready));
        chk("cdb_valid", row, 32'(cdb_valid), 32'(v.e_cv));
        if (v.e_cv) begin
            chk("cdb_tag", row, 32'(cdb_tag), 32'(v.e_tag));
            chk("cdb_data", row, cdb_data, v.e_data);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);

        //   rst  fail valid    tb  db            e_ready  cv tag data
        add(1'b1, 1'b0, 4'b1111, 0,  0,            4'b0000, 0, 0,  0);
        add(1'b0, 1'b0, 4'b0100, 3,  0,            4'b0100, 0, 0,  0);
        add(1'b0, 1'b0, 4'b0000, 0,  32'hDEADBEED, 4'b0000, 1, 5,  32'hDEADBEEF);
        add(1'b0, 1'b0, 4'b0000, 0,  0,            4'b0000, 0, 0,  0);
`ifdef CDB_ARB_RR_EN
        add(1'b0, 1'b0, 4'b0110, 10, 0,            4'b0010, 0, 0,  0);
        add(1'b0, 1'b0, 4'b0110, 20, 100,          4'b0100, 1, 11, 101);
        add(1'b0, 1'b0, 4'b0110, 30, 200,          4'b0010, 1, 22, 202);
`else
        add(1'b0, 1'b0, 4'b0110, 10, 0,            4'b0010, 0, 0,  0);
        add(1'b0, 1'b0, 4'b0110, 20, 100,          4'b0010, 1, 11, 101);
        add(1'b0, 1'b0, 4'b0110, 30, 200,          4'b0010, 1, 21, 201);
`endif
        add(1'b0, 1'b0, 4'b0000, 0,  300,          4'b0000, 1, 31, 301);
        add(1'b0, 1'b0, 4'b0001, 1,  0,            4'b0001, 0, 0,  0);
        add(1'b0, 1'b0, 4'b0001, 2,  32'h1000,     4'b0001, 1, 1,  32'h1000);
        add(1'b0, 1'b0, 4'b0001, 3,  32'h2000,     4'b0001, 1, 2,  32'h2000);
        add(1'b0, 1'b0, 4'b0000, 0,  32'h3000,     4'b0000, 1, 3,  32'h3000);
        add(1'b0, 1'b0, 4'b0000, 0,  0,            4'b0000, 0, 0,  0);
        add(1'b0, 1'b0, 4'b0001, 7,  0,            4'b0001, 0, 0,  0);
        add(1'b0, 1'b1, 4'b0001, 9,  32'h77,       4'b0000, 1, 7,  32'h77);
        add(1'b0, 1'b1, 4'b0001, 9,  0,            4'b0000, 0, 0,  0);
        add(1'b0, 1'b0, 4'b0000, 0,  0,            4'b0000, 0, 0,  0);
        add(1'b0, 1'b0, 4'b1000, 40, 0,            4'b1000, 0, 0,  0);
        add(1'b1, 1'b0, 4'b1000, 0,  32'h500,      4'b0000, 1, 43, 32'h503);
        add(1'b0, 1'b0, 4'b1100, 50, 0,            4'b0100, 0, 0,  0);
        add(1'b0, 1'b0, 4'b0000, 0,  32'h600,      4'b0000, 1, 52, 32'h602);
        add(1'b0, 1'b0, 4'b0000, 0,  0,            4'b0000, 0, 0,  0);

        for (int r = 0; r < vecs.size(); r++) step_check(r, vecs[r]);

        // All four requesting straight out of reset: grants walk 0,1,2,3 then wrap (RR)
        // or stay on 0 (fixed priority); each broadcast carries the previous grant's tag.
        begin
            vec_t v;
            int   prev_g;
            v.rst = 1'b1; v.fail = 1'b0; v.valid = 4'b1111; v.tb = 0; v.db = 0;
            v.e_ready = 4'b0000; v.e_cv = 1'b0; v.e_tag = 0; v.e_data = 0;
            step_check(100, v);
            prev_g = -1;
            for (int k = 0; k < 6; k++) begin
                int g;
`ifdef CDB_ARB_RR_EN
                g = k % N;
`else
                g = 0;
`endif
                v.rst = 1'b0; v.valid = (k < 5) ? 4'b1111 : 4'b0000;
                v.tb = TW'(k * 8); v.db = DW'(k * 32'h100);
                v.e_ready = (k < 5) ? 4'(1 << g) : 4'b0000;
                v.e_cv    = (k > 0);
                v.e_tag   = TW'((k - 1) * 8 + prev_g);
                v.e_data  = DW'(k * 32'h100 + prev_g);
                step_check(101 + k, v);
                prev_g = g;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
